// File: rtl/gray_counter_sched.sv
// -----------------------------------------------------------------------------
// gray_counter_sched
//   Round-robin scheduler that shares one gray_counter between NREQ requesters.
//   Each granted burst optionally clears the counter, then issues req_len
//   clock-enable pulses. A shadow binary count tracks what the counter holds.
//
// Optional feature macro: GRAY_SCHED_ABORT_EN
//   When defined, adds input 'abort' (ends a RUN burst early) and output
//   'done_aborted' (qualifies 'done').
//
// Ports:
//   clk_counter, reset_counter_n : counter-domain clock, async active-low reset
//   req_valid/req_len/req_clear  : per-requester burst request (len field i at
//                                  [i*BURST_W +: BURST_W])
//   req_ready                    : one-hot accept strobe (combinational, IDLE)
//   hold                         : pauses increments while in RUN
//   ce, counter_clear            : counter enable / synchronous clear
//   grant_id                     : current/last granted requester
//   busy, done, done_id          : status; done is a one-cycle pulse
//   shadow_count, wrap           : expected counter value and rollover pulse
// -----------------------------------------------------------------------------
module gray_counter_sched #(
    parameter int NREQ    = 4,
    parameter int LENGTH  = 8,
    parameter int BURST_W = 8
) (
    input  logic                       clk_counter,
    input  logic                       reset_counter_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*BURST_W-1:0]    req_len,
    input  logic [NREQ-1:0]            req_clear,
    input  logic                       hold,
`ifdef GRAY_SCHED_ABORT_EN
    input  logic                       abort,
    output logic                       done_aborted,
`endif
    output logic                       ce,
    output logic                       counter_clear,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NREQ)-1:0]    done_id,
    output logic [LENGTH-2:0]          shadow_count,
    output logic                       wrap
);

    localparam int IDW = $clog2(NREQ);
    localparam int SW  = LENGTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic [BURST_W-1:0] r_rem;
    logic [IDW-1:0]     r_grant;
    logic [IDW-1:0]     r_last;
    logic [SW-1:0]      r_shadow;

    logic               w_found;
    logic [IDW-1:0]     w_pick;
    logic [BURST_W-1:0] w_pick_len;
    logic               w_accept;
    logic               w_ce;
    logic               w_clr;
    logic               w_abort;

`ifdef GRAY_SCHED_ABORT_EN
    logic               r_aborted;
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Round-robin search starting just after the last completed grant.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = IDW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_pick_len = req_len[w_pick*BURST_W +: BURST_W];

    // ce/counter_clear are decoded from the state register and gated by
    // hold/abort so a pause or abort takes effect in the same cycle.
    always_comb begin
        w_state_n = r_state;
        w_ce      = 1'b0;
        w_clr     = 1'b0;
        w_accept  = 1'b0;
        req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept          = 1'b1;
                    req_ready[w_pick] = 1'b1;
                    if (req_clear[w_pick])
                        w_state_n = S_CLEAR;
                    else if (w_pick_len == '0)
                        w_state_n = S_DONE;
                    else
                        w_state_n = S_RUN;
                end
            end
            S_CLEAR: begin
                w_clr     = 1'b1;
                w_state_n = (r_rem != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (w_abort) begin
                    w_state_n = S_DONE;
                end else if (!hold) begin
                    w_ce = 1'b1;
                    if (r_rem == BURST_W'(1))
                        w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_counter or negedge reset_counter_n) begin
        if (!reset_counter_n) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_grant  <= '0;
            r_last   <= IDW'(NREQ - 1);
            r_shadow <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_accept) begin
                r_rem   <= w_pick_len;
                r_grant <= w_pick;
            end else if (w_ce) begin
                r_rem <= r_rem - 1'b1;
            end
            if (r_state == S_DONE)
                r_last <= r_grant;
            if (w_clr)
                r_shadow <= '0;
            else if (w_ce)
                r_shadow <= r_shadow + 1'b1;
        end
    end

`ifdef GRAY_SCHED_ABORT_EN
    always_ff @(posedge clk_counter or negedge reset_counter_n) begin
        if (!reset_counter_n)
            r_aborted <= 1'b0;
        else if (w_accept)
            r_aborted <= 1'b0;
        else if (r_state == S_RUN && abort)
            r_aborted <= 1'b1;
    end
    assign done_aborted = (r_state == S_DONE) && r_aborted;
`endif

    assign ce            = w_ce;
    assign counter_clear = w_clr;
    assign grant_id      = r_grant;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign done_id       = done ? r_grant : '0;
    assign shadow_count  = r_shadow;
    // Rollover coincides with the ce that takes the shadow from all-ones to 0.
    assign wrap          = w_ce && (r_shadow == {SW{1'b1}});

endmodule

// File: tb/tb_gray_counter_sched.sv
module tb_gray_counter_sched;

    localparam int NREQ    = 4;
    localparam int LENGTH  = 8;
    localparam int BURST_W = 8;
    localparam int IDW     = $clog2(NREQ);
    localparam int SMOD    = 1 << (LENGTH - 1);

    logic                    clk_counter = 1'b0;
    logic                    reset_counter_n = 1'b0;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*BURST_W-1:0] req_len = '0;
    logic [NREQ-1:0]         req_clear = '0;
    logic                    hold = 1'b0;
`ifdef GRAY_SCHED_ABORT_EN
    logic                    abort = 1'b0;
    logic                    done_aborted;
`endif
    logic                    ce, counter_clear, busy, done, wrap;
    logic [IDW-1:0]          grant_id, done_id;
    logic [LENGTH-2:0]       shadow_count;

    gray_counter_sched #(.NREQ(NREQ), .LENGTH(LENGTH), .BURST_W(BURST_W)) dut (
        .clk_counter     (clk_counter),
        .reset_counter_n (reset_counter_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_len         (req_len),
        .req_clear       (req_clear),
        .hold            (hold),
`ifdef GRAY_SCHED_ABORT_EN
        .abort           (abort),
        .done_aborted    (done_aborted),
`endif
        .ce              (ce),
        .counter_clear   (counter_clear),
        .grant_id        (grant_id),
        .busy            (busy),
        .done            (done),
        .done_id         (done_id),
        .shadow_count    (shadow_count),
        .wrap            (wrap)
    );

    always #5 clk_counter = ~clk_counter;

    int n_chk = 0;
    int n_err = 0;

    // Requester-side view: pending flags and their request fields.
    logic [NREQ-1:0] pend = '0;
    int              plen [NREQ];
    bit              pclr [NREQ];

    // Transaction-level model of the scheduler.
    bit m_busy = 0;
    int m_last = NREQ - 1;
    int m_shadow = 0;
    int m_k, m_len, m_cnt, m_id;
    bit m_clr, m_ab;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got %0h exp %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic step(input bit gen);
        int pick;
        bit exp_ready, exp_ce, exp_clr, exp_done, exp_busy;
        for (int i = 0; i < NREQ; i++) begin
            if (gen && !pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i] = 1'b1;
                plen[i] = ($urandom_range(0, 39) == 0) ? 255 : int'($urandom_range(0, 12));
                pclr[i] = ($urandom_range(0, 4) == 0);
            end
            req_len[i*BURST_W +: BURST_W] = pend[i] ? BURST_W'(plen[i]) : BURST_W'($urandom);
            req_clear[i] = pend[i] ? pclr[i] : 1'($urandom);
        end
        req_valid = pend;
        hold = ($urandom_range(0, 3) == 0);
`ifdef GRAY_SCHED_ABORT_EN
        abort = ($urandom_range(0, 19) == 0);
`endif
        @(negedge clk_counter);
        exp_ready = 0; exp_ce = 0; exp_clr = 0; exp_done = 0; pick = 0;
        exp_busy = m_busy;
        if (!m_busy) begin
            for (int k = NREQ; k >= 1; k--)
                if (pend[(m_last + k) % NREQ]) begin
                    pick = (m_last + k) % NREQ;
                    exp_ready = 1;
                end
        end else begin
            m_k++;
            if (m_clr && m_k == 1)
                exp_clr = 1;
            else if (m_cnt == m_len || m_ab)
                exp_done = 1;
            else begin
                exp_ce = !hold;
`ifdef GRAY_SCHED_ABORT_EN
                if (abort) begin
                    exp_ce = 0;
                    m_ab = 1;
                end
`endif
            end
        end
        check("req_ready", 32'(req_ready), exp_ready ? (32'd1 << pick) : 32'd0);
        check("ce", 32'(ce), 32'(exp_ce));
        check("counter_clear", 32'(counter_clear), 32'(exp_clr));
        check("done", 32'(done), 32'(exp_done));
        check("busy", 32'(busy), 32'(exp_busy));
        check("shadow_count", 32'(shadow_count), 32'(m_shadow));
        check("wrap", 32'(wrap), 32'(exp_ce && m_shadow == SMOD - 1));
        if (exp_busy) check("grant_id", 32'(grant_id), 32'(m_id));
        if (exp_done) check("done_id", 32'(done_id), 32'(m_id));
`ifdef GRAY_SCHED_ABORT_EN
        check("done_aborted", 32'(done_aborted), 32'(exp_done && m_ab));
`endif
        if (exp_ready) begin
            m_busy = 1; m_k = 0; m_cnt = 0; m_ab = 0;
            m_len = plen[pick]; m_clr = pclr[pick]; m_id = pick;
            pend[pick] = 1'b0;
        end
        if (exp_clr) m_shadow = 0;
        if (exp_ce) begin
            m_shadow = (m_shadow + 1) % SMOD;
            m_cnt++;
        end
        if (exp_done) begin
            m_busy = 0;
            m_last = m_id;
        end
        @(posedge clk_counter);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"}, 32'(ce), 32'd0);
        check({tag, "_clear"}, 32'(counter_clear), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_shadow"}, 32'(shadow_count), 32'd0);
        check({tag, "_wrap"}, 32'(wrap), 32'd0);
        check({tag, "_grant"}, 32'(grant_id), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            plen[i] = 0;
            pclr[i] = 0;
        end
        repeat (3) @(posedge clk_counter);
        #1;
        check_reset_outputs("rst");
        check("rst_done_id", 32'(done_id), 32'd0);
        reset_counter_n = 1'b1;
        @(posedge clk_counter);
        #1;

        // Single burst from requester 0, then randomized traffic.
        pend[0] = 1'b1; plen[0] = 5; pclr[0] = 0;
        for (int c = 0; c < 4000; c++) step(c > 8);

        // Let all outstanding work finish.
        for (int c = 0; c < 3000 && (m_busy || pend != '0); c++) step(0);
        check("drain_busy", 32'(busy), 32'd0);

        // Reset in the middle of a burst: outputs drop at once, burst is lost.
        pend = '0;
        pend[2] = 1'b1; plen[2] = 10; pclr[2] = 0;
        repeat (4) step(0);
        reset_counter_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_busy = 0; m_last = NREQ - 1; m_shadow = 0; pend = '0;
        @(negedge clk_counter);
        reset_counter_n = 1'b1;
        @(posedge clk_counter);
        #1;

        // All four request at once: order must restart at requester 0.
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1; plen[i] = 1; pclr[i] = 0;
        end
        repeat (20) step(0);
        check("rr_restart_last", 32'(m_last), 32'(NREQ - 1));
        check("rr_restart_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
